// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM stage of the pipelined RV64 core. Consumes the EX/MEM pipeline register,
// performs data-memory loads/stores over a variable-latency req/ack port,
// stalls the upstream pipeline while an access is outstanding, resolves
// beq/bgt branches and registers results into the MEM/WB pipeline register.
//
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   defined   : accesses with EX_MEM_ALU[2:0] != 0 are dropped (no request,
//               no stall), misalign_err pulses for that cycle and MEM/WB
//               receives a bubble.
//   undefined : misalign_err is tied low, addresses pass unchecked.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-low reset
//   EX_MEM_*            inputs from the EX/MEM pipeline register
//   dmem_req/we/addr/wdata  registered data-memory request
//   dmem_ack/rdata      memory completion and load data
//   mem_stall           freeze upstream pipeline (combinational)
//   PCSrc, branch_target  branch resolution (combinational)
//   MEM_WB_*            registered MEM/WB pipeline register outputs
//   mem_timeout         sticky abort flag, cleared only by reset
//   misalign_err        one-cycle misaligned-access pulse
// -----------------------------------------------------------------------------
module mem_access_stage #(
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        EX_MEM_Rd,
   input  logic [DATA_W-1:0] EX_MEM_ALU,
   input  logic [DATA_W-1:0] EX_MEM_MUX_FB,
   input  logic [DATA_W-1:0] EX_MEM_Adder,
   input  logic              EX_MEM_Zero,
   input  logic              EX_MEM_Great,
   input  logic              EX_MEM_BranchEq,
   input  logic              EX_MEM_BranchGt,
   input  logic              EX_MEM_MemRead,
   input  logic              EX_MEM_MemWrite,
   input  logic              EX_MEM_RegWrite,
   input  logic              EX_MEM_MemtoReg,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              mem_stall,
   output logic              PCSrc,
   output logic [DATA_W-1:0] branch_target,
   output logic [4:0]        MEM_WB_Rd,
   output logic [DATA_W-1:0] MEM_WB_ReadData,
   output logic [DATA_W-1:0] MEM_WB_ALU,
   output logic              MEM_WB_RegWrite,
   output logic              MEM_WB_MemtoReg,
   output logic              mem_timeout,
   output logic              misalign_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   capt_q, capt_d;
   logic                timeout_q, timeout_d;
   logic [4:0]          wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0]   wb_rdata_q, wb_rdata_d;
   logic [DATA_W-1:0]   wb_alu_q, wb_alu_d;
   logic                wb_regwrite_q, wb_regwrite_d;
   logic                wb_memtoreg_q, wb_memtoreg_d;
   logic                stall_s;
   logic                acc_s;
   logic                mis_s;

   assign acc_s = EX_MEM_MemRead | EX_MEM_MemWrite;

`ifdef MEM_MISALIGN_CHECK_EN
   // Only a fresh access decoded in IDLE is checked; in-flight ones already passed.
   assign mis_s = (state_q == ST_IDLE) & acc_s & (EX_MEM_ALU[2:0] != 3'b000);
`else
   assign mis_s = 1'b0;
`endif

   // Next-state, request and MEM/WB update logic.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      req_d         = req_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      capt_d        = capt_q;
      timeout_d     = timeout_q;
      wb_rd_d       = wb_rd_q;
      wb_rdata_d    = wb_rdata_q;
      wb_alu_d      = wb_alu_q;
      wb_regwrite_d = wb_regwrite_q;
      wb_memtoreg_d = wb_memtoreg_q;
      stall_s       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (acc_s && !mis_s) begin
               stall_s       = 1'b1;
               state_d       = ST_ACCESS;
               req_d         = 1'b1;
               // MemRead wins when both controls are set.
               we_d          = ~EX_MEM_MemRead;
               addr_d        = EX_MEM_ALU;
               wdata_d       = EX_MEM_MUX_FB;
               cnt_d         = '0;
               wb_regwrite_d = 1'b0;
               wb_memtoreg_d = 1'b0;
            end else if (mis_s) begin
               wb_regwrite_d = 1'b0;
               wb_memtoreg_d = 1'b0;
            end else begin
               wb_rd_d       = EX_MEM_Rd;
               wb_alu_d      = EX_MEM_ALU;
               wb_regwrite_d = EX_MEM_RegWrite;
               wb_memtoreg_d = EX_MEM_MemtoReg;
            end
         end
         ST_ACCESS: begin
            stall_s       = 1'b1;
            wb_regwrite_d = 1'b0;
            wb_memtoreg_d = 1'b0;
            if (dmem_ack) begin
               capt_d  = dmem_rdata;
               req_d   = 1'b0;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               capt_d    = '0;
               req_d     = 1'b0;
               timeout_d = 1'b1;
               state_d   = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            // EX/MEM still holds the accessing instruction (it was stalled).
            wb_rd_d       = EX_MEM_Rd;
            wb_alu_d      = EX_MEM_ALU;
            wb_regwrite_d = EX_MEM_RegWrite;
            wb_memtoreg_d = EX_MEM_MemtoReg;
            wb_rdata_d    = capt_q;
            state_d       = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State and pipeline registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         req_q         <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         capt_q        <= '0;
         timeout_q     <= 1'b0;
         wb_rd_q       <= 5'd0;
         wb_rdata_q    <= '0;
         wb_alu_q      <= '0;
         wb_regwrite_q <= 1'b0;
         wb_memtoreg_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         req_q         <= req_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         capt_q        <= capt_d;
         timeout_q     <= timeout_d;
         wb_rd_q       <= wb_rd_d;
         wb_rdata_q    <= wb_rdata_d;
         wb_alu_q      <= wb_alu_d;
         wb_regwrite_q <= wb_regwrite_d;
         wb_memtoreg_q <= wb_memtoreg_d;
      end
   end

   assign dmem_req        = req_q;
   assign dmem_we         = we_q;
   assign dmem_addr       = addr_q;
   assign dmem_wdata      = wdata_q;
   assign mem_stall       = stall_s;
   assign PCSrc           = (EX_MEM_Zero & EX_MEM_BranchEq) | (EX_MEM_Great & EX_MEM_BranchGt);
   assign branch_target   = EX_MEM_Adder;
   assign MEM_WB_Rd       = wb_rd_q;
   assign MEM_WB_ReadData = wb_rdata_q;
   assign MEM_WB_ALU      = wb_alu_q;
   assign MEM_WB_RegWrite = wb_regwrite_q;
   assign MEM_WB_MemtoReg = wb_memtoreg_q;
   assign mem_timeout     = timeout_q;
   assign misalign_err    = mis_s;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Directed self-checking bench for mem_access_stage. Inputs change on the
// falling edge; registered outputs are sampled on the falling edge and
// combinational outputs #1 after an input change.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

   logic        clk;
   logic        reset;
   logic [4:0]  EX_MEM_Rd;
   logic [63:0] EX_MEM_ALU, EX_MEM_MUX_FB, EX_MEM_Adder;
   logic        EX_MEM_Zero, EX_MEM_Great, EX_MEM_BranchEq, EX_MEM_BranchGt;
   logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_MemtoReg;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        mem_stall, PCSrc;
   logic [63:0] branch_target;
   logic [4:0]  MEM_WB_Rd;
   logic [63:0] MEM_WB_ReadData, MEM_WB_ALU;
   logic        MEM_WB_RegWrite, MEM_WB_MemtoReg;
   logic        mem_timeout, misalign_err;

   int n_assert = 0;
   int n_fail   = 0;

   mem_access_stage #(.DATA_W(64), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .reset(reset),
      .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_ALU(EX_MEM_ALU), .EX_MEM_MUX_FB(EX_MEM_MUX_FB),
      .EX_MEM_Adder(EX_MEM_Adder), .EX_MEM_Zero(EX_MEM_Zero), .EX_MEM_Great(EX_MEM_Great),
      .EX_MEM_BranchEq(EX_MEM_BranchEq), .EX_MEM_BranchGt(EX_MEM_BranchGt),
      .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
      .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemtoReg(EX_MEM_MemtoReg),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .mem_stall(mem_stall), .PCSrc(PCSrc), .branch_target(branch_target),
      .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_ReadData(MEM_WB_ReadData), .MEM_WB_ALU(MEM_WB_ALU),
      .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_MemtoReg(MEM_WB_MemtoReg),
      .mem_timeout(mem_timeout), .misalign_err(misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nop();
      EX_MEM_Rd = 5'd0; EX_MEM_ALU = 64'd0; EX_MEM_MUX_FB = 64'd0; EX_MEM_Adder = 64'd0;
      EX_MEM_Zero = 1'b0; EX_MEM_Great = 1'b0; EX_MEM_BranchEq = 1'b0; EX_MEM_BranchGt = 1'b0;
      EX_MEM_MemRead = 1'b0; EX_MEM_MemWrite = 1'b0; EX_MEM_RegWrite = 1'b0; EX_MEM_MemtoReg = 1'b0;
   endtask

   initial begin
      reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = 64'd0;
      nop();
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req", dmem_req, 64'd0);
      chk("rst_addr", dmem_addr, 64'd0);
      chk("rst_wb_regwrite", MEM_WB_RegWrite, 64'd0);
      chk("rst_timeout", mem_timeout, 64'd0);
      chk("rst_misalign", misalign_err, 64'd0);
      reset = 1'b1;

      // ALU op, no memory access
      EX_MEM_Rd = 5'd5; EX_MEM_ALU = 64'h2A; EX_MEM_RegWrite = 1'b1;
      #1 chk("alu_stall", mem_stall, 64'd0);
      @(negedge clk);
      chk("alu_wb_rd", MEM_WB_Rd, 64'd5);
      chk("alu_wb_alu", MEM_WB_ALU, 64'h2A);
      chk("alu_wb_regwrite", MEM_WB_RegWrite, 64'd1);

      // Load, ack in the 3rd ACCESS cycle -> 4 stall cycles
      EX_MEM_Rd = 5'd7; EX_MEM_ALU = 64'h100; EX_MEM_MemRead = 1'b1; EX_MEM_MemtoReg = 1'b1;
      #1 chk("ld_stall_c1", mem_stall, 64'd1);
      chk("ld_req_pre", dmem_req, 64'd0);
      @(negedge clk);
      chk("ld_req", dmem_req, 64'd1);
      chk("ld_addr", dmem_addr, 64'h100);
      chk("ld_we", dmem_we, 64'd0);
      chk("ld_bubble", MEM_WB_RegWrite, 64'd0);
      chk("ld_stall_c2", mem_stall, 64'd1);
      @(negedge clk);
      chk("ld_stall_c3", mem_stall, 64'd1);
      @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = 64'hDEAD_BEEF;
      #1 chk("ld_stall_c4", mem_stall, 64'd1);
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = 64'd0;
      chk("ld_resp_stall", mem_stall, 64'd0);
      chk("ld_resp_req", dmem_req, 64'd0);
      chk("ld_resp_bubble", MEM_WB_RegWrite, 64'd0);
      @(negedge clk);
      chk("ld_wb_rdata", MEM_WB_ReadData, 64'hDEAD_BEEF);
      chk("ld_wb_memtoreg", MEM_WB_MemtoReg, 64'd1);
      chk("ld_wb_regwrite", MEM_WB_RegWrite, 64'd1);
      chk("ld_wb_rd", MEM_WB_Rd, 64'd7);
      nop();
      @(negedge clk);
      chk("ld_once", MEM_WB_RegWrite, 64'd0);

      // Store, 1-cycle ack
      EX_MEM_ALU = 64'h80; EX_MEM_MUX_FB = 64'h55; EX_MEM_MemWrite = 1'b1;
      #1 chk("st_stall_c1", mem_stall, 64'd1);
      @(negedge clk);
      chk("st_req", dmem_req, 64'd1);
      chk("st_we", dmem_we, 64'd1);
      chk("st_wdata", dmem_wdata, 64'h55);
      chk("st_addr", dmem_addr, 64'h80);
      dmem_ack = 1'b1;
      #1 chk("st_stall_c2", mem_stall, 64'd1);
      @(negedge clk);
      dmem_ack = 1'b0;
      chk("st_resp_stall", mem_stall, 64'd0);
      @(negedge clk);
      chk("st_wb_regwrite", MEM_WB_RegWrite, 64'd0);
      chk("st_wb_alu", MEM_WB_ALU, 64'h80);
      nop();

      // Branch resolution
      EX_MEM_BranchEq = 1'b1; EX_MEM_Zero = 1'b1; EX_MEM_Adder = 64'h400;
      #1 chk("beq_taken", PCSrc, 64'd1);
      chk("beq_target", branch_target, 64'h400);
      EX_MEM_Zero = 1'b0;
      #1 chk("beq_not_taken", PCSrc, 64'd0);
      EX_MEM_BranchEq = 1'b0; EX_MEM_BranchGt = 1'b1; EX_MEM_Great = 1'b1;
      #1 chk("bgt_taken", PCSrc, 64'd1);
      nop();
      @(negedge clk);

      // Load with no ack -> timeout after 16 ACCESS cycles
      EX_MEM_Rd = 5'd9; EX_MEM_ALU = 64'h200; EX_MEM_MemRead = 1'b1;
      EX_MEM_MemtoReg = 1'b1; EX_MEM_RegWrite = 1'b1;
      @(negedge clk);
      chk("to_req_first", dmem_req, 64'd1);
      repeat (15) @(negedge clk);
      chk("to_req_last", dmem_req, 64'd1);
      chk("to_flag_pre", mem_timeout, 64'd0);
      @(negedge clk);
      chk("to_req_drop", dmem_req, 64'd0);
      chk("to_flag", mem_timeout, 64'd1);
      chk("to_resume", mem_stall, 64'd0);
      @(negedge clk);
      chk("to_wb_rdata", MEM_WB_ReadData, 64'd0);
      chk("to_wb_rd", MEM_WB_Rd, 64'd9);
      nop();
      @(negedge clk);
      chk("to_sticky", mem_timeout, 64'd1);

      // Reset in the middle of an access; later ack is ignored
      EX_MEM_Rd = 5'd3; EX_MEM_ALU = 64'h300; EX_MEM_MemRead = 1'b1; EX_MEM_RegWrite = 1'b1;
      @(negedge clk);
      chk("mr_req", dmem_req, 64'd1);
      reset = 1'b0;
      @(negedge clk);
      chk("mr_req_drop", dmem_req, 64'd0);
      chk("mr_addr", dmem_addr, 64'd0);
      chk("mr_timeout", mem_timeout, 64'd0);
      chk("mr_wb_rd", MEM_WB_Rd, 64'd0);
      nop();
      reset = 1'b1;
      dmem_ack = 1'b1; dmem_rdata = 64'h1234;
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = 64'd0;
      chk("mr_ack_ign_req", dmem_req, 64'd0);
      chk("mr_ack_ign_stall", mem_stall, 64'd0);
      @(negedge clk);
      chk("mr_ack_ign_rdata", MEM_WB_ReadData, 64'd0);

`ifdef MEM_MISALIGN_CHECK_EN
      // Misaligned load is dropped with a one-cycle error pulse
      EX_MEM_RegWrite = 1'b1; @(negedge clk);
      EX_MEM_ALU = 64'h103; EX_MEM_MemRead = 1'b1; EX_MEM_MemtoReg = 1'b1;
      #1 chk("mis_err", misalign_err, 64'd1);
      chk("mis_stall", mem_stall, 64'd0);
      @(negedge clk);
      chk("mis_req", dmem_req, 64'd0);
      chk("mis_bubble", MEM_WB_RegWrite, 64'd0);
      nop();
      #1 chk("mis_err_clr", misalign_err, 64'd0);
`else
      // Without the check the misaligned address is issued as-is
      EX_MEM_ALU = 64'h103; EX_MEM_MemRead = 1'b1;
      #1 chk("mis_tied", misalign_err, 64'd0);
      chk("mis_stall_on", mem_stall, 64'd1);
      @(negedge clk);
      chk("mis_addr_pass", dmem_addr, 64'h103);
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
      nop();
      @(negedge clk);
`endif
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
